// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared control-unit constants, select encodings and sequencer states
package cu_pkg;

  // Opcode classes that need non-default register-file selects
  localparam int unsigned OPC_STACK = 7;   // PUSH / POP
  localparam int unsigned OPC_BRX   = 11;  // JMP / CALL / RET / RTI
  localparam int unsigned OPC_MEM   = 12;  // LDM / LDD / STD

  // ra field codes under OPC_STACK
  localparam int unsigned RA_PUSH = 0;
  localparam int unsigned RA_POP  = 1;

  // brx field codes under OPC_BRX
  localparam int unsigned BRX_JMP  = 0;
  localparam int unsigned BRX_CALL = 1;
  localparam int unsigned BRX_RET  = 2;
  localparam int unsigned BRX_RTI  = 3;

  // Read-B MUX encodings
  localparam logic [1:0] SD3_RB  = 2'd0;  // R[rb]
  localparam logic [1:0] SD3_PC1 = 2'd1;  // PC+1
  localparam logic [1:0] SD3_IPC = 2'd2;  // interrupted PC
  localparam logic [1:0] SD3_CCR = 2'd3;  // CCR

  // Sequencer states: push PC then CCR on interrupt entry, pop both on RTI
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INT_PC  = 3'd1,
    ST_INT_CCR = 3'd2,
    ST_RTI_PC  = 3'd3,
    ST_RTI_CCR = 3'd4
  } seq_state_t;

endpackage

// File: rtl/d_regsel_decode.sv
// rtl/d_regsel_decode.sv - single-cycle opcode/ra_brx to register-file select decoder
module d_regsel_decode
  import cu_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int REG_W = 2
) (
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [REG_W-1:0] i_ra_brx,
  output logic             o_sd1,
  output logic             o_sd2,
  output logic [1:0]       o_sd3,
  output logic             o_is_rti
);

  // Decode: start from defaults (ra write, R[ra], R[rb]) and override per class
  always_comb begin
    o_sd1    = 1'b0;
    o_sd2    = 1'b1;
    o_sd3    = SD3_RB;
    o_is_rti = 1'b0;
    if (i_opcode == OPC_W'(OPC_STACK)) begin
      // PUSH/POP address the stack pointer; the other two ra codes keep defaults
      if ((i_ra_brx == REG_W'(RA_PUSH)) || (i_ra_brx == REG_W'(RA_POP))) begin
        o_sd1 = 1'b1;
      end
    end else if (i_opcode == OPC_W'(OPC_MEM)) begin
      o_sd2 = 1'b0;
    end else if (i_opcode == OPC_W'(OPC_BRX)) begin
      if (i_ra_brx == REG_W'(BRX_CALL)) begin
        o_sd1 = 1'b1;
        o_sd3 = SD3_PC1;
      end else if (i_ra_brx == REG_W'(BRX_RET)) begin
        o_sd1 = 1'b1;
      end else if (i_ra_brx == REG_W'(BRX_RTI)) begin
        o_sd1    = 1'b1;
        o_is_rti = 1'b1;
      end else if (i_ra_brx == REG_W'(BRX_JMP)) begin
        o_sd1 = 1'b0;
      end
    end
  end

endmodule

// File: rtl/d_regsel_seq.sv
// rtl/d_regsel_seq.sv - registered register-file selects with interrupt/RTI sequencer and fetch handshake
module d_regsel_seq
  import cu_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int REG_W  = 2,
  parameter int SP_IDX = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [REG_W-1:0] i_ra_brx,
  input  logic             i_instr_valid,
  output logic             o_instr_ready,
  input  logic             i_int_req,
  input  logic             i_stall,
  output logic             o_sd1,
  output logic             o_sd2,
  output logic [1:0]       o_sd3,
  output logic [REG_W-1:0] o_wr_addr,
  output logic             o_seq_busy,
  output logic             o_int_ack
);

  seq_state_t       r_state;
  logic             r_sd1;
  logic             r_sd2;
  logic [1:0]       r_sd3;
  logic [REG_W-1:0] r_ra_cap;
  logic [REG_W-1:0] r_wr_addr;
  logic             r_int_ack;

  seq_state_t       w_state_nxt;
  logic             w_sd1_nxt;
  logic             w_sd2_nxt;
  logic [1:0]       w_sd3_nxt;
  logic [REG_W-1:0] w_ra_cap_nxt;
  logic [REG_W-1:0] w_wr_addr_nxt;
  logic             w_int_ack_nxt;
  logic             w_consume;

  logic             w_dec_sd1;
  logic             w_dec_sd2;
  logic [1:0]       w_dec_sd3;
  logic             w_dec_is_rti;

  d_regsel_decode #(
    .OPC_W (OPC_W),
    .REG_W (REG_W)
  ) u_decode (
    .i_opcode (i_opcode),
    .i_ra_brx (i_ra_brx),
    .o_sd1    (w_dec_sd1),
    .o_sd2    (w_dec_sd2),
    .o_sd3    (w_dec_sd3),
    .o_is_rti (w_dec_is_rti)
  );

  // Fetch may only hand over an instruction while idle and not pre-empted by an interrupt or freeze
  assign o_instr_ready = (r_state == ST_IDLE) && !i_int_req && !i_stall;
  assign w_consume     = i_instr_valid && o_instr_ready;

  // Next state and next registered selects; every state starts from the default selects
  always_comb begin
    w_state_nxt   = r_state;
    w_sd1_nxt     = 1'b0;
    w_sd2_nxt     = 1'b1;
    w_sd3_nxt     = SD3_RB;
    w_ra_cap_nxt  = r_ra_cap;
    w_int_ack_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_int_req) begin
          // Interrupt wins over a waiting instruction, which stays unconsumed
          w_state_nxt = ST_INT_PC;
          w_sd1_nxt   = 1'b1;
          w_sd3_nxt   = SD3_IPC;
        end else if (w_consume) begin
          w_ra_cap_nxt = i_ra_brx;
          w_sd1_nxt    = w_dec_sd1;
          w_sd2_nxt    = w_dec_sd2;
          w_sd3_nxt    = w_dec_sd3;
          if (w_dec_is_rti) begin
            w_state_nxt = ST_RTI_PC;
          end
        end
      end
      ST_INT_PC: begin
        w_state_nxt = ST_INT_CCR;
        w_sd1_nxt   = 1'b1;
        w_sd3_nxt   = SD3_CCR;
      end
      ST_INT_CCR: begin
        w_state_nxt   = ST_IDLE;
        w_int_ack_nxt = 1'b1;
      end
      ST_RTI_PC: begin
        // Second pop uses the same stack-pointer selects as the first
        w_state_nxt = ST_RTI_CCR;
        w_sd1_nxt   = 1'b1;
        w_sd3_nxt   = SD3_RB;
      end
      ST_RTI_CCR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_wr_addr_nxt = w_sd1_nxt ? REG_W'(SP_IDX) : w_ra_cap_nxt;
  end

  // State and select registers; a stall freezes everything except int_ack, which is held low
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_sd1     <= 1'b0;
      r_sd2     <= 1'b1;
      r_sd3     <= SD3_RB;
      r_ra_cap  <= '0;
      r_wr_addr <= '0;
      r_int_ack <= 1'b0;
    end else if (i_stall) begin
      r_int_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sd1     <= w_sd1_nxt;
      r_sd2     <= w_sd2_nxt;
      r_sd3     <= w_sd3_nxt;
      r_ra_cap  <= w_ra_cap_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_int_ack <= w_int_ack_nxt;
    end
  end

  assign o_sd1      = r_sd1;
  assign o_sd2      = r_sd2;
  assign o_sd3      = r_sd3;
  assign o_wr_addr  = r_wr_addr;
  assign o_int_ack  = r_int_ack;
  assign o_seq_busy = (r_state != ST_IDLE);

endmodule

// File: doc/d_regsel_seq.md
# d_regsel_seq

Parametrised, sequenced successor to the decode-stage register-file MUX-select logic. Decodes the instruction in the D stage into registered select signals for the three MUXes in front of the register file (write address, read A, read B). Adds a multi-cycle sequencer for interrupt entry and RTI, so that PC and CCR are pushed and popped in separate cycles. Also adds a ready/valid handshake back to fetch, and a configurable stack-pointer register index.

## Interface
- `OPC_W`, default 4: opcode width.
- `REG_W`, default 2: register address width.
- `SP_IDX`, default 3: register index used as SP.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in OPC_W: IR[7:4].
- `ra_brx` in REG_W: IR ra/brx field.
- `instr_valid` in 1: D-stage instruction present.
- `instr_ready` out 1: instruction accepted this cycle. Combinational.
- `int_req` in 1: registered interrupt request. Level.
- `stall` in 1: hazard-unit freeze.
- `sd1` out 1: write-address select. 0 = ra, 1 = SP_IDX.
- `sd2` out 1: read-A select. 0 = Imm, 1 = R[ra].
- `sd3` out 2: read-B select. 0 = R[rb], 1 = PC+1, 2 = interrupted PC, 3 = CCR.
- `wr_addr` out REG_W: resolved write address, `sd1 ? SP_IDX : ra_brx` (the ra_brx captured at decode).
- `seq_busy` out 1: sequencer in a multi-cycle state.
- `int_ack` out 1: one-cycle pulse when interrupt entry completes.

## Operation
- FSM states: `IDLE`, `INT_PC`, `INT_CCR`, `RTI_PC`, `RTI_CCR`.
- Handshake:
  - `instr_ready` = (state==IDLE) && !int_req && !stall.
  - An instruction is consumed only when `instr_valid` && `instr_ready`.
- IDLE, no consume and no interrupt: outputs return to defaults, `sd1`=0, `sd2`=1, `sd3`=0.
- IDLE with `int_req` && !stall:
  - Go to `INT_PC`.
  - Outputs: `sd1`=1, `sd2`=1, `sd3`=2.
  - `int_req` has priority over a simultaneous valid instruction; that instruction is not consumed.
- `INT_PC`:
  - Go to `INT_CCR`.
  - Outputs: `sd1`=1, `sd2`=1, `sd3`=3.
- `INT_CCR`: go to `IDLE`, pulse `int_ack`.
- Consumed RTI (opcode 11, brx 3):
  - Go to `RTI_PC`.
  - Outputs: `sd1`=1, `sd2`=1, `sd3`=0.
- `RTI_PC`: go to `RTI_CCR`. Outputs unchanged.
- `RTI_CCR`: go to `IDLE`.
- Single-cycle decode of consumed instructions:
  - Opcode 7, ra 0 or 1 (PUSH/POP): `sd1`=1, `sd2`=1, `sd3`=0.
  - Opcode 7, ra 2 or 3: `sd1`=0.
  - Opcode 12 (LDM/LDD/STD): `sd1`=0, `sd2`=0, `sd3`=0.
  - Opcode 11, brx 1 (CALL): `sd1`=1, `sd3`=1.
  - Opcode 11, brx 2 (RET): `sd1`=1, `sd3`=0.
  - Opcode 11, brx 0 (JMP): defaults.
  - All other opcodes: defaults.
- `seq_busy`=1 in every state other than IDLE.
- `int_req` arriving mid-RTI: ignored until IDLE, then serviced. RTI always completes both pops.

## Timing
- Reset values:
  - Registers: state=IDLE, `sd1`=0, `sd2`=1, `sd3`=0, `wr_addr`=0, `int_ack`=0.
  - Combinational `instr_ready`: follows its formula, so it is 1 out of reset if `int_req`=0 and `stall`=0.
- Latency: select outputs are registered, appearing one cycle after the consume or transition cycle.
- Interrupt entry: 3 cycles from the IDLE sample of `int_req` to the `int_ack` pulse.
- RTI: occupies 2 cycles after consume; `instr_ready` is low for both.
- `stall`=1 freezes the state register, `sd*`, and `wr_addr`. `int_ack` is forced to 0 during a stall and is emitted on the first non-stalled `INT_CCR` exit.
- `rst` mid-sequence: IDLE next cycle, no `int_ack`, partial push is abandoned.

## Structure
- Shared package `cu_pkg` holds:
  - Opcode constants: 7, 11, 12.
  - PUSH/POP ra codes.
  - brx codes: JMP 0, CALL 1, RET 2, RTI 3.
  - `sd3` encoding constants.
  - FSM state enum.
- One natural sub-module, `d_regsel_decode`: pure-combinational opcode/ra_brx to {sd1, sd2, sd3, is_rti} decoder used in IDLE. The sequencer wraps it.

## Test plan
- After `rst`, `opcode`=7, `ra_brx`=0, `instr_valid`=1 -> next cycle `sd1`=1, `sd2`=1, `sd3`=0, `wr_addr`=3.
- `opcode`=12 valid -> `sd1`=0, `sd2`=0, `sd3`=0. Then `opcode`=11, brx=1 -> `sd1`=1, `sd3`=1.
- `int_req`=1 in IDLE together with a valid ADD:
  - `instr_ready`=0.
  - `sd3` sequence is 2, 3.
  - `int_ack` is high exactly once, in cycle 3.
  - ADD is accepted afterwards.
- RTI consumed:
  - `seq_busy`=1 for 2 cycles, `sd1`=1, `sd3`=0.
  - `int_req` raised in `RTI_PC` is serviced only after `RTI_CCR`.
- `stall` held 3 cycles while in `INT_PC`: outputs frozen at `sd3`=2, no `int_ack`. Sequence resumes on release.
- `rst` asserted in `INT_CCR` -> IDLE, defaults restored, no `int_ack` pulse.
